analog_ctrl_sequencer: RTL and testbench



---
 rtl/analog_ctrl_sequencer_if.sv | 22 ++
 rtl/analog_ctrl_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_analog_ctrl_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/analog_ctrl_sequencer_if.sv
// APB slave bundle for the analog control-word sequencer.
// Signal names keep the block's port names so the bus reads the same at every level.
interface analog_ctrl_sequencer_if;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [5:0]  paddr_i;
    logic [31:0] pwdata_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, paddr_i, pwdata_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/analog_ctrl_sequencer.sv
// Plays up to four APB-programmed control words to the analog block, each held
// DWELL+1 cycles, one-shot or looping; presents IDLE_WORD between sequences.
module analog_ctrl_sequencer #(
    parameter int CTRL_W  = 16,
    parameter int DWELL_W = 16
) (
    input  logic                  clk_in,
    input  logic                  reset_int,
    analog_ctrl_sequencer_if.slave apb,
    output logic [CTRL_W-1:0]     control_o,
    output logic                  busy_o,
    output logic                  irq_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    // Configuration registers
    logic                r_loop;
    logic [1:0]          r_last;
    logic                r_done;
    logic [DWELL_W-1:0]  r_dwell;
    logic [CTRL_W-1:0]   r_idle_word;
    logic [CTRL_W-1:0]   r_seq [4];

    // Sequencer state
    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_idx;
    logic [1:0]          w_idx_nxt;
    logic [DWELL_W-1:0]  r_cnt;
    logic [DWELL_W-1:0]  w_cnt_nxt;
    logic [CTRL_W-1:0]   r_control;
    logic [CTRL_W-1:0]   w_control_nxt;
    logic                r_irq;
    logic                w_irq_nxt;
    logic                w_done_set;

    // APB decode
    logic                w_access;
    logic                w_addr_err;
    logic                w_wr;
    logic [2:0]          w_reg_sel;
    logic                w_wr_ctrl;
    logic                w_start;
    logic                w_stop;
    logic                w_wr_status;
    logic                w_wr_dwell;
    logic                w_wr_idle;
    logic                w_wr_seq;
    logic [CTRL_W-1:0]   w_idle_word;
    logic [1:0]          w_idx_inc;
    logic [31:0]         w_rdata;
    logic                w_unused_apb;

    assign w_access    = apb.psel_i & apb.penable_i;
    assign w_addr_err  = (apb.paddr_i > 6'h1C);
    assign w_wr        = w_access & apb.pwrite_i & ~w_addr_err;
    assign w_reg_sel   = apb.paddr_i[4:2];
    assign w_wr_ctrl   = w_wr && (w_reg_sel == 3'd0);
    assign w_wr_status = w_wr && (w_reg_sel == 3'd1);
    assign w_wr_dwell  = w_wr && (w_reg_sel == 3'd2);
    assign w_wr_idle   = w_wr && (w_reg_sel == 3'd3);
    assign w_wr_seq    = w_wr && w_reg_sel[2];
    // STOP dominates a combined START|STOP write.
    assign w_stop      = w_wr_ctrl & apb.pwdata_i[1];
    assign w_start     = w_wr_ctrl & apb.pwdata_i[0] & ~apb.pwdata_i[1];
    assign w_unused_apb = ^{apb.pwdata_i, apb.paddr_i};

    // A new idle word shows up on the same edge that accepts the write.
    assign w_idle_word = w_wr_idle ? apb.pwdata_i[CTRL_W-1:0] : r_idle_word;
    assign w_idx_inc   = r_idx + 2'd1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            r_loop      <= 1'b0;
            r_last      <= 2'd0;
            r_done      <= 1'b0;
            r_dwell     <= '0;
            r_idle_word <= '0;
            // NOTE: the four-entry word store is plain flops, so it is reset like any register.
            for (int i = 0; i < 4; i++) r_seq[i] <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_loop <= apb.pwdata_i[2];
                r_last <= apb.pwdata_i[5:4];
            end
            if (w_wr_dwell) r_dwell     <= apb.pwdata_i[DWELL_W-1:0];
            if (w_wr_idle)  r_idle_word <= apb.pwdata_i[CTRL_W-1:0];
            if (w_wr_seq)   r_seq[w_reg_sel[1:0]] <= apb.pwdata_i[CTRL_W-1:0];
            if (w_done_set)
                r_done <= 1'b1;
            else if (w_wr_status && apb.pwdata_i[1])
                r_done <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_cnt     <= '0;
            r_control <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_control <= w_control_nxt;
            r_irq     <= w_irq_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_control_nxt = r_control;
        w_irq_nxt     = 1'b0;
        w_done_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_control_nxt = w_idle_word;
                if (w_start) begin
                    w_state_nxt   = S_RUN;
                    w_idx_nxt     = 2'd0;
                    w_control_nxt = r_seq[0];
                    w_cnt_nxt     = r_dwell;
                end
            end
            S_RUN: begin
                if (w_stop) begin
                    w_state_nxt   = S_IDLE;
                    w_control_nxt = w_idle_word;
                end else if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end else if (r_idx < r_last) begin
                    w_idx_nxt     = w_idx_inc;
                    w_control_nxt = r_seq[w_idx_inc];
                    w_cnt_nxt     = r_dwell;
                end else if (r_loop) begin
                    w_idx_nxt     = 2'd0;
                    w_control_nxt = r_seq[0];
                    w_cnt_nxt     = r_dwell;
                end else begin
                    // Last step finished (also covers LAST lowered below IDX mid-run).
                    w_state_nxt   = S_IDLE;
                    w_control_nxt = w_idle_word;
                    w_done_set    = 1'b1;
                    w_irq_nxt     = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rdata = '0;
        if (apb.psel_i && !apb.pwrite_i && !w_addr_err) begin
            case (w_reg_sel)
                3'd0: begin
                    w_rdata[2]   = r_loop;
                    w_rdata[5:4] = r_last;
                end
                3'd1: begin
                    w_rdata[0]   = (r_state == S_RUN);
                    w_rdata[1]   = r_done;
                    w_rdata[5:4] = r_idx;
                end
                3'd2:    w_rdata[DWELL_W-1:0] = r_dwell;
                3'd3:    w_rdata[CTRL_W-1:0]  = r_idle_word;
                default: w_rdata[CTRL_W-1:0]  = r_seq[w_reg_sel[1:0]];
            endcase
        end
    end

    assign apb.prdata_o  = w_rdata;
    assign apb.pready_o  = 1'b1;
    assign apb.pslverr_o = w_access & w_addr_err;

    assign control_o = r_control;
    assign busy_o    = (r_state == S_RUN);
    assign irq_o     = r_irq;

endmodule

// File: tb/tb_analog_ctrl_sequencer.sv
// Self-checking bench: APB register vector table, hand-built timing sequences, and
// randomized sequences compared against a cycle-arithmetic model of the playout.
module tb_analog_ctrl_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_int;
    logic [15:0] control_o;
    logic        busy_o;
    logic        irq_o;

    always #5 clk_in = ~clk_in;

    analog_ctrl_sequencer_if apb_if ();

    analog_ctrl_sequencer #(.CTRL_W(16), .DWELL_W(16)) dut (
        .clk_in    (clk_in),
        .reset_int (reset_int),
        .apb       (apb_if),
        .control_o (control_o),
        .busy_o    (busy_o),
        .irq_o     (irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of the programmed sequence; cycle 1 is the first cycle after START is accepted.
    int          m_cyc;
    int          m_stop_at;
    int          m_last;
    int          m_dwell;
    int          m_loop;
    logic        m_done;
    logic [15:0] m_seq [4];
    logic [15:0] m_idle;

    typedef struct {
        logic        wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [5:0] addr, input logic [31:0] data, output logic err);
        @(negedge clk_in);
        m_cyc++;
        apb_if.psel_i    = 1'b1;
        apb_if.penable_i = 1'b0;
        apb_if.pwrite_i  = 1'b1;
        apb_if.paddr_i   = addr;
        apb_if.pwdata_i  = data;
        @(negedge clk_in);
        m_cyc++;
        apb_if.penable_i = 1'b1;
        #1 err = apb_if.pslverr_o;
        @(posedge clk_in);
        #1;
        apb_if.psel_i    = 1'b0;
        apb_if.penable_i = 1'b0;
        apb_if.pwrite_i  = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] addr, output logic [31:0] data, output logic err);
        @(negedge clk_in);
        m_cyc++;
        apb_if.psel_i    = 1'b1;
        apb_if.penable_i = 1'b0;
        apb_if.pwrite_i  = 1'b0;
        apb_if.paddr_i   = addr;
        @(negedge clk_in);
        m_cyc++;
        apb_if.penable_i = 1'b1;
        #1;
        data = apb_if.prdata_o;
        err  = apb_if.pslverr_o;
        @(posedge clk_in);
        #1;
        apb_if.psel_i    = 1'b0;
        apb_if.penable_i = 1'b0;
    endtask

    function automatic void model(input int c, output logic [15:0] w, output logic b, output logic q);
        int n;
        n = (m_last + 1) * (m_dwell + 1);
        w = m_idle;
        b = 1'b0;
        q = 1'b0;
        if (m_stop_at >= 0 && c > m_stop_at) begin
            w = m_idle;
        end else if (m_loop != 0) begin
            w = m_seq[((c - 1) / (m_dwell + 1)) % (m_last + 1)];
            b = 1'b1;
        end else if (c <= n) begin
            w = m_seq[(c - 1) / (m_dwell + 1)];
            b = 1'b1;
        end else begin
            q = (c == n + 1);
        end
    endfunction

    function automatic logic [31:0] ctrl_bits();
        return 32'((m_last << 4) | (m_loop << 2));
    endfunction

    task automatic tick_check();
        logic [15:0] w;
        logic        b;
        logic        q;
        @(negedge clk_in);
        m_cyc++;
        model(m_cyc, w, b, q);
        check($sformatf("control c=%0d", m_cyc), 32'(control_o), 32'(w));
        check($sformatf("busy c=%0d", m_cyc), 32'(busy_o), 32'(b));
        check($sformatf("irq c=%0d", m_cyc), 32'(irq_o), 32'(q));
    endtask

    task automatic cfg(input int last, input int dwell, input int lp,
                       input logic [15:0] s0, input logic [15:0] s1,
                       input logic [15:0] s2, input logic [15:0] s3,
                       input logic [15:0] idle);
        logic e;
        m_last = last; m_dwell = dwell; m_loop = lp;
        m_seq[0] = s0; m_seq[1] = s1; m_seq[2] = s2; m_seq[3] = s3;
        m_idle = idle;
        apb_write(6'h08, 32'(dwell), e);
        apb_write(6'h10, {16'h0, s0}, e);
        apb_write(6'h14, {16'h0, s1}, e);
        apb_write(6'h18, {16'h0, s2}, e);
        apb_write(6'h1C, {16'h0, s3}, e);
        apb_write(6'h0C, {16'h0, idle}, e);
        check("idle word on next edge", 32'(control_o), 32'(idle));
    endtask

    task automatic start_seq();
        logic e;
        apb_write(6'h00, ctrl_bits() | 32'h1, e);
        m_cyc = 0;
        m_stop_at = -1;
    endtask

    task automatic stop_seq();
        logic e;
        apb_write(6'h00, ctrl_bits() | 32'h2, e);
        m_stop_at = m_cyc;
        if (m_loop == 0 && m_stop_at >= (m_last + 1) * (m_dwell + 1) + 1) m_done = 1'b1;
    endtask

    task automatic check_done(input string name);
        logic [31:0] st;
        logic        e;
        apb_read(6'h04, st, e);
        check(name, st & 32'hFFFF_FFCF, {30'h0, m_done, 1'b0});
    endtask

    task automatic clear_done();
        logic e;
        apb_write(6'h04, 32'h2, e);
        m_done = 1'b0;
    endtask

    task automatic add_vec(input logic wr, input logic [5:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          n;
        int          k;
        bit          do_stop;

        m_cyc = 0; m_stop_at = 0; m_done = 1'b0;
        m_last = 0; m_dwell = 0; m_loop = 0; m_idle = '0;
        for (int i = 0; i < 4; i++) m_seq[i] = '0;
        apb_if.psel_i = 1'b0; apb_if.penable_i = 1'b0; apb_if.pwrite_i = 1'b0;
        apb_if.paddr_i = '0; apb_if.pwdata_i = '0;

        // Power-on reset
        reset_int = 1'b0;
        repeat (3) @(negedge clk_in);
        check("reset control", 32'(control_o), 32'h0);
        check("reset busy", 32'(busy_o), 32'h0);
        check("reset irq", 32'(irq_o), 32'h0);
        check("reset prdata", apb_if.prdata_o, 32'h0);
        check("reset pslverr", 32'(apb_if.pslverr_o), 32'h0);
        check("pready tied", 32'(apb_if.pready_o), 32'h1);
        reset_int = 1'b1;

        // Reset asserted mid-sequence aborts at once
        cfg(3, 4, 0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0F0F);
        start_seq();
        repeat (3) tick_check();
        #2 reset_int = 1'b0;
        #1;
        check("midrun reset control", 32'(control_o), 32'h0);
        check("midrun reset busy", 32'(busy_o), 32'h0);
        @(negedge clk_in);
        reset_int = 1'b1;
        @(negedge clk_in);
        check("post reset control", 32'(control_o), 32'h0);

        // Register table: all zero after reset, then write/readback and error handling
        add_vec(0, 6'h00, 0, 32'h0, 0);
        add_vec(0, 6'h04, 0, 32'h0, 0);
        add_vec(0, 6'h08, 0, 32'h0, 0);
        add_vec(0, 6'h0C, 0, 32'h0, 0);
        add_vec(0, 6'h10, 0, 32'h0, 0);
        add_vec(0, 6'h14, 0, 32'h0, 0);
        add_vec(0, 6'h18, 0, 32'h0, 0);
        add_vec(0, 6'h1C, 0, 32'h0, 0);
        add_vec(1, 6'h08, 32'hFFFF_1234, 32'h0, 0);
        add_vec(0, 6'h08, 0, 32'h0000_1234, 0);
        add_vec(1, 6'h0C, 32'hABCD_00F0, 32'h0, 0);
        add_vec(0, 6'h0C, 0, 32'h0000_00F0, 0);
        add_vec(1, 6'h10, 32'h0000_5A5A, 32'h0, 0);
        add_vec(0, 6'h10, 0, 32'h0000_5A5A, 0);
        add_vec(1, 6'h1C, 32'h0001_C3C3, 32'h0, 0);
        add_vec(0, 6'h1C, 0, 32'h0000_C3C3, 0);
        add_vec(1, 6'h00, 32'hFFFF_FFFC, 32'h0, 0);
        add_vec(0, 6'h00, 0, 32'h0000_0034, 0);
        add_vec(1, 6'h00, 32'h0000_0000, 32'h0, 0);
        add_vec(0, 6'h00, 0, 32'h0000_0000, 0);
        add_vec(0, 6'h20, 0, 32'h0000_0000, 1);
        add_vec(1, 6'h3C, 32'h0000_9999, 32'h0, 1);
        add_vec(0, 6'h08, 0, 32'h0000_1234, 0);
        add_vec(0, 6'h0C, 0, 32'h0000_00F0, 0);
        add_vec(0, 6'h3C, 0, 32'h0000_0000, 1);
        add_vec(1, 6'h20, 32'h0000_7777, 32'h0, 1);
        add_vec(0, 6'h10, 0, 32'h0000_5A5A, 0);
        add_vec(1, 6'h04, 32'hFFFF_FFFF, 32'h0, 0);
        add_vec(0, 6'h04, 0, 32'h0000_0000, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].wdata, e);
            end else begin
                apb_read(vecs[i].addr, rd, e);
                check($sformatf("vec%0d rdata @%02h", i, vecs[i].addr), rd, vecs[i].exp_rdata);
            end
            check($sformatf("vec%0d pslverr @%02h", i, vecs[i].addr), 32'(e), 32'(vecs[i].exp_err));
        end

        // One-shot: three words, three cycles each, then idle word with a single irq
        cfg(2, 2, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h00F0);
        start_seq();
        repeat (11) tick_check();
        m_done = 1'b1;
        check_done("oneshot done set");
        clear_done();
        check_done("done w1c");

        // Loop with DWELL=0 alternates every cycle, STOP returns to idle without DONE
        cfg(1, 0, 1, 16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h00F0);
        start_seq();
        repeat (6) tick_check();
        stop_seq();
        repeat (3) tick_check();
        check_done("loop stop done clear");

        // START while running is ignored; IDX reads back mid-run
        cfg(3, 3, 0, 16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'h5555);
        start_seq();
        repeat (2) tick_check();
        apb_write(6'h00, ctrl_bits() | 32'h1, e);
        repeat (2) tick_check();
        apb_read(6'h04, rd, e);
        check("status mid-run", rd, 32'((((m_cyc - 1) / (m_dwell + 1)) << 4) | 1));
        while (m_cyc < 19) tick_check();
        m_done = 1'b1;
        apb_read(6'h00, rd, e);
        check("ctrl start reads 0", rd, 32'h0000_0030);
        clear_done();

        // Shortest sequence: one word for one cycle
        cfg(0, 0, 0, 16'hBEEF, 16'h0002, 16'h0003, 16'h0004, 16'h1234);
        start_seq();
        repeat (3) tick_check();
        m_done = 1'b1;
        check_done("short done");
        clear_done();

        // START|STOP together from idle does nothing
        apb_write(6'h00, 32'h0000_0003, e);
        m_last = 0; m_loop = 0;
        m_cyc = 0; m_stop_at = 0;
        repeat (3) tick_check();
        check_done("start+stop idle");

        // Randomized sequences against the cycle-arithmetic model
        for (int it = 0; it < 20; it++) begin
            cfg($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 1),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            n = (m_last + 1) * (m_dwell + 1);
            do_stop = (m_loop != 0) || ($urandom_range(0, 1) == 1);
            start_seq();
            if (do_stop) begin
                k = (m_loop != 0) ? $urandom_range(1, 12) : $urandom_range(1, n + 4);
                repeat (k) tick_check();
                stop_seq();
                repeat (3) tick_check();
            end else begin
                repeat (n + 3) tick_check();
                m_done = 1'b1;
            end
            check_done($sformatf("rand%0d done", it));
            if ($urandom_range(0, 1) == 1) clear_done();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
